par2ser_stream: RTL and testbench
=================================

# par2ser_stream

Parametrised parallel-to-serial streamer for the CNN datapath. Captures NUM_CH words of DATA_W bits from a flat parallel bus on a begin_wr strobe and emits them one word per accepted cycle with a valid/ready handshake. It generalises the fixed 8×8-bit serialiser with:
- configurable width and channel count,
- per-frame length and direction,
- downstream backpressure,
- a one-deep pending frame buffer for gap-free back-to-back frames.

## Interface
- DATA_W, 8, bits per word
- NUM_CH, 8, words per full frame (≥1)
- LEN_W, $clog2(NUM_CH+1), width of len port

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- begin_wr  in  1  frame capture strobe; sampled each edge
- din  in  NUM_CH*DATA_W  parallel words; word i = din[i*DATA_W +: DATA_W]
- len  in  LEN_W  words to send; 0 or >NUM_CH means NUM_CH; sampled with begin_wr
- rev  in  1  0: word 0 first, ascending; 1: word len-1 first, descending; sampled with begin_wr
- dout  out  DATA_W  current output word (registered)
- outen  out  1  dout valid (registered)
- out_ready  in  1  downstream accepts; transfer = outen & out_ready at an edge
- last  out  1  high with the final word of a frame
- busy  out  1  frame active or pending
- overflow  out  1  one-cycle pulse: begin_wr dropped

## Operation
- Storage: active buffer plus word index; pending buffer with pend_valid, len and rev.
- States:
  - IDLE: outen=0.
  - SEND: outen=1, dout = active word at index.
- IDLE, begin_wr=1: load active buffer from din/len/rev and enter SEND. First word is presented after the same edge.
- SEND, transfer, not last: index advances; next word presented after that edge, no bubble.
- SEND, transfer of last word:
  - pend_valid=1: pending moves to active, pend_valid cleared, first word of the new frame presented after the same edge.
  - else, begin_wr=1 on the same edge: new frame loads directly to active, no bubble.
  - else: go to IDLE, outen=0.
- SEND, no transfer: dout, last and index hold. dout never changes while outen=1 and out_ready=0.
- begin_wr in SEND, not coinciding with the last transfer:
  - pend_valid=0: capture into pending, pend_valid=1.
  - pend_valid=1: frame dropped; overflow=1 for the next cycle.
- begin_wr coinciding with last transfer while pend_valid=1: pending promotes, new frame captured into pending. No drop.
- last = outen & (index is the final word of the frame): index = len_eff-1 when rev=0, 0 when rev=1.
- busy = outen | pend_valid.
- len_eff = NUM_CH if len==0 or len>NUM_CH, else len. len_eff=1 gives a single-word frame with last=1 on that word.
- din is not required to be stable after its capture edge.

## Timing
- Reset (rst=1 at an edge): dout=0, outen=0, last=0, busy=0, overflow=0, pend_valid=0, state IDLE. Reset overrides begin_wr on the same edge and aborts any frame mid-stream; no partial words are emitted afterwards.
- Latency: begin_wr sampled at edge k (IDLE) → outen=1 with the first word after edge k.
- Throughput: one word per cycle with out_ready held high, including across frame boundaries when a pending frame exists.
- A frame of len_eff words with out_ready=1 occupies exactly len_eff cycles of outen.
- overflow asserted one cycle after the dropping edge, low otherwise.
- Output changes only at rising edges; no combinational path from inputs to outputs.

## Test plan
All scenarios use DATA_W=8, NUM_CH=8, din=0x0706050403020100 unless stated.
- Basic: out_ready=1, len=0, rev=0, one-cycle begin_wr → 8 consecutive outen cycles, dout 00,01,…,07; last only on 07; busy low the cycle after 07.
- Length/direction: len=3, rev=1 → dout 02,01,00, last on 00. len=9 → full 8 words. len=1 → single word 00 with last=1.
- Backpressure: out_ready pattern 1,0,1,0,… → each word held stable while out_ready=0. Eight transfers complete in 16 cycles, data 00..07 in order.
- Back-to-back: second begin_wr with din=0x1F1E1D1C1B1A1918 during word 03 → stream 00..07 then 18..1F with no gap; last on 07 and 1F. A third begin_wr while pending is full → overflow pulse one cycle later, frame never appears.
- Reset mid-frame: rst=1 after word 02 is accepted, with a pending frame loaded → next cycle all outputs 0, busy=0. A subsequent begin_wr restarts from 00.
- Boundary: begin_wr on the same edge as the last transfer, with pending empty → next frame's first word appears immediately, no idle cycle, no overflow.

Source files
------------

// File: rtl/par2ser_stream.sv
// Parallel-to-serial word streamer: captures NUM_CH words on begin_wr and emits
// them one per accepted cycle, with a one-deep pending frame for gap-free chaining.
module par2ser_stream #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned LEN_W  = $clog2(NUM_CH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     begin_wr,
  input  logic [NUM_CH*DATA_W-1:0] din,
  input  logic [LEN_W-1:0]         len,
  input  logic                     rev,
  output logic [DATA_W-1:0]        dout,
  output logic                     outen,
  input  logic                     out_ready,
  output logic                     last,
  output logic                     busy,
  output logic                     overflow
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef logic [NUM_CH-1:0][DATA_W-1:0] buf_t;
  typedef enum logic {IDLE, SEND} state_e;

  state_e             state_q, state_d;
  buf_t               act_buf_q, act_buf_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   fin_q, fin_d;
  logic               rev_q, rev_d;
  buf_t               pend_buf_q, pend_buf_d;
  logic [IDX_W-1:0]   pend_first_q, pend_first_d;
  logic [IDX_W-1:0]   pend_fin_q, pend_fin_d;
  logic               pend_rev_q, pend_rev_d;
  logic               pend_valid_q, pend_valid_d;
  logic               ovf_q, ovf_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;

  logic [IDX_W-1:0]   in_last_idx;
  logic [IDX_W-1:0]   in_first;
  logic [IDX_W-1:0]   in_fin;
  logic               xfer;
  logic               at_last;

  // Index of the final word for a requested length (0 or oversize means full frame).
  function automatic logic [IDX_W-1:0] len_last(input logic [LEN_W-1:0] l);
    if (l == '0 || 32'(l) > NUM_CH) return IDX_W'(NUM_CH - 1);
    else                            return IDX_W'(l - 1'b1);
  endfunction

  assign in_last_idx = len_last(len);
  assign in_first    = rev ? in_last_idx : '0;
  assign in_fin      = rev ? '0 : in_last_idx;
  assign xfer        = (state_q == SEND) && out_ready;
  assign at_last     = (idx_q == fin_q);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      act_buf_q    <= '0;
      idx_q        <= '0;
      fin_q        <= '0;
      rev_q        <= 1'b0;
      pend_buf_q   <= '0;
      pend_first_q <= '0;
      pend_fin_q   <= '0;
      pend_rev_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      dout_q       <= '0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_buf_q    <= act_buf_d;
      idx_q        <= idx_d;
      fin_q        <= fin_d;
      rev_q        <= rev_d;
      pend_buf_q   <= pend_buf_d;
      pend_first_q <= pend_first_d;
      pend_fin_q   <= pend_fin_d;
      pend_rev_q   <= pend_rev_d;
      pend_valid_q <= pend_valid_d;
      ovf_q        <= ovf_d;
      dout_q       <= dout_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state: frame loading, index stepping, pending promotion and drop detection
  always_comb begin
    state_d      = state_q;
    act_buf_d    = act_buf_q;
    idx_d        = idx_q;
    fin_d        = fin_q;
    rev_d        = rev_q;
    pend_buf_d   = pend_buf_q;
    pend_first_d = pend_first_q;
    pend_fin_d   = pend_fin_q;
    pend_rev_d   = pend_rev_q;
    pend_valid_d = pend_valid_q;
    ovf_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (begin_wr) begin
          state_d   = SEND;
          act_buf_d = din;
          idx_d     = in_first;
          fin_d     = in_fin;
          rev_d     = rev;
        end
      end
      SEND: begin
        if (xfer && at_last) begin
          if (pend_valid_q) begin
            act_buf_d = pend_buf_q;
            idx_d     = pend_first_q;
            fin_d     = pend_fin_q;
            rev_d     = pend_rev_q;
            if (begin_wr) begin
              pend_buf_d   = din;
              pend_first_d = in_first;
              pend_fin_d   = in_fin;
              pend_rev_d   = rev;
            end else begin
              pend_valid_d = 1'b0;
            end
          end else if (begin_wr) begin
            act_buf_d = din;
            idx_d     = in_first;
            fin_d     = in_fin;
            rev_d     = rev;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (xfer) idx_d = rev_q ? idx_q - 1'b1 : idx_q + 1'b1;
          if (begin_wr) begin
            if (!pend_valid_q) begin
              pend_buf_d   = din;
              pend_first_d = in_first;
              pend_fin_d   = in_fin;
              pend_rev_d   = rev;
              pend_valid_d = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from next state so every output leaves a flop
  always_comb begin
    dout_d = dout_q;
    if (state_d == SEND) dout_d = act_buf_d[idx_d];
    last_d = (state_d == SEND) && (idx_d == fin_d);
    busy_d = (state_d == SEND) || pend_valid_d;
  end

  assign dout     = dout_q;
  assign outen    = (state_q == SEND);
  assign last     = last_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_par2ser_stream.sv
// Self-checking bench for par2ser_stream against a queue-of-words reference model.
module tb_par2ser_stream;

  logic        clk;
  logic        rst;
  logic        begin_wr;
  logic [63:0] din;
  logic [3:0]  len;
  logic        rev;
  logic [7:0]  dout;
  logic        outen;
  logic        out_ready;
  logic        last;
  logic        busy;
  logic        overflow;

  int n_cmp;
  int n_err;

  // Model: words still to be emitted, bit 8 marks a frame's final word.
  logic [8:0] exp_q[$];
  logic       ovf_exp;

  localparam logic [63:0] D0 = 64'h0706050403020100;
  localparam logic [63:0] D1 = 64'h1F1E1D1C1B1A1918;

  par2ser_stream #(.DATA_W(8), .NUM_CH(8), .LEN_W(4)) dut (
    .clk(clk), .rst(rst), .begin_wr(begin_wr), .din(din), .len(len), .rev(rev),
    .dout(dout), .outen(outen), .out_ready(out_ready), .last(last),
    .busy(busy), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] obs_vec();
    return {outen, last, busy, overflow, dout};
  endfunction

  function automatic logic [11:0] exp_vec();
    if (exp_q.size() > 0) return {1'b1, exp_q[0][8], 1'b1, ovf_exp, exp_q[0][7:0]};
    return {3'b000, ovf_exp, 8'h00};
  endfunction

  // dout is only meaningful while a word is presented
  function automatic logic [11:0] exp_mask();
    return (exp_q.size() > 0) ? 12'hFFF : 12'hF00;
  endfunction

  // Drive one cycle of inputs, clock it, and advance the model by the same edge.
  task automatic tick(input logic bw, input logic [63:0] d, input logic [3:0] l,
                      input logic r, input logic rdy);
    int fr;
    int le;
    int ix;
    begin_wr = bw; din = d; len = l; rev = r; out_ready = rdy;
    @(posedge clk);
    if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
    fr = 0;
    foreach (exp_q[i]) if (exp_q[i][8]) fr++;
    ovf_exp = 1'b0;
    if (bw) begin
      if (fr < 2) begin
        le = (l == 0 || l > 8) ? 8 : int'(l);
        for (int k = 0; k < le; k++) begin
          ix = r ? le - 1 - k : k;
          exp_q.push_back({(k == le - 1), d[ix*8 +: 8]});
        end
      end else begin
        ovf_exp = 1'b1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    exp_q.delete();
    ovf_exp = 1'b0;
    #1;
    rst = 1'b0;
    begin_wr = 1'b0;
  endtask

  task automatic test_reset();
    begin_wr = 1'b1; din = D0; len = 4'd0; rev = 1'b0; out_ready = 1'b1;
    do_reset();
    n_cmp++;
    if (obs_vec() !== 12'h000) begin
      n_err++;
      $display("FAIL reset_state: got %h want 000", obs_vec());
    end
  endtask

  task automatic test_basic();
    do_reset();
    tick(1'b1, D0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (outen !== 1'b1 || dout !== 8'(i) || last !== (i == 7)) begin
        n_err++;
        $display("FAIL basic_word%0d: got outen=%b dout=%h last=%b want 1 %h %b",
                 i, outen, dout, last, 8'(i), (i == 7));
      end
      n_cmp++;
      if (((obs_vec() ^ exp_vec()) & exp_mask()) !== 12'h000) begin
        n_err++;
        $display("FAIL basic_model: got %h want %h", obs_vec(), exp_vec());
      end
      tick(1'b0, 64'h0, 4'd0, 1'b0, 1'b1);
    end
    n_cmp++;
    if (outen !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_end: got outen=%b busy=%b want 0 0", outen, busy);
    end
  endtask

  task automatic test_len_dir();
    logic [3:0] lens[3];
    logic       revs[3];
    int         want[3];
    logic [7:0] first_w[3];
    int         cnt;
    logic [7:0] first;
    lens = '{4'd3, 4'd9, 4'd1};
    revs = '{1'b1, 1'b0, 1'b0};
    want = '{3, 8, 1};
    first_w = '{8'h02, 8'h00, 8'h00};
    for (int f = 0; f < 3; f++) begin
      do_reset();
      tick(1'b1, D0, lens[f], revs[f], 1'b1);
      cnt = 0;
      first = 8'hxx;
      for (int c = 0; c < 12; c++) begin
        n_cmp++;
        if (((obs_vec() ^ exp_vec()) & exp_mask()) !== 12'h000) begin
          n_err++;
          $display("FAIL lendir_model%0d: got %h want %h", f, obs_vec(), exp_vec());
        end
        if (outen === 1'b1) begin
          if (cnt == 0) first = dout;
          cnt++;
        end
        tick(1'b0, 64'h0, 4'd0, 1'b0, 1'b1);
      end
      n_cmp++;
      if (cnt != want[f] || first !== first_w[f]) begin
        n_err++;
        $display("FAIL lendir_frame%0d: got %0d words first %h want %0d first %h",
                 f, cnt, first, want[f], first_w[f]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] got[$];
    logic       rdy;
    logic       prev_rdy;
    logic [7:0] prev_dout;
    do_reset();
    tick(1'b1, D0, 4'd0, 1'b0, 1'b1);
    prev_rdy = 1'b1;
    prev_dout = 8'h00;
    for (int c = 0; c < 16; c++) begin
      rdy = (c % 2 == 0);
      n_cmp++;
      if (((obs_vec() ^ exp_vec()) & exp_mask()) !== 12'h000) begin
        n_err++;
        $display("FAIL bp_model: got %h want %h", obs_vec(), exp_vec());
      end
      if (!prev_rdy) begin
        n_cmp++;
        if (outen !== 1'b1 || dout !== prev_dout) begin
          n_err++;
          $display("FAIL bp_hold: got outen=%b dout=%h want 1 %h", outen, dout, prev_dout);
        end
      end
      if (outen === 1'b1 && rdy) got.push_back(dout);
      prev_rdy = rdy;
      prev_dout = dout;
      tick(1'b0, 64'h0, 4'd0, 1'b0, rdy);
    end
    n_cmp++;
    if (got.size() != 8 || outen !== 1'b0) begin
      n_err++;
      $display("FAIL bp_count: got %0d transfers outen=%b want 8 0", got.size(), outen);
    end
    foreach (got[i]) begin
      n_cmp++;
      if (got[i] !== 8'(i)) begin
        n_err++;
        $display("FAIL bp_data%0d: got %h want %h", i, got[i], 8'(i));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got[$];
    logic [63:0] d2;
    int          busy_cycles;
    d2 = {$urandom, $urandom};
    do_reset();
    tick(1'b1, D0, 4'd0, 1'b0, 1'b1);
    busy_cycles = 0;
    for (int c = 0; c < 18; c++) begin
      n_cmp++;
      if (((obs_vec() ^ exp_vec()) & exp_mask()) !== 12'h000) begin
        n_err++;
        $display("FAIL b2b_model c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (c >= 4 && c <= 6) begin
        n_cmp++;
        if (overflow !== (c == 5)) begin
          n_err++;
          $display("FAIL b2b_overflow c%0d: got %b want %b", c, overflow, (c == 5));
        end
      end
      if (outen === 1'b1) begin
        got.push_back(dout);
        if (c < 16) busy_cycles++;
        if (dout == 8'h07 || dout == 8'h1F) begin
          n_cmp++;
          if (last !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_last: got last=%b on %h want 1", last, dout);
          end
        end
      end
      tick((c == 3) || (c == 4), (c == 3) ? D1 : d2, 4'd0, 1'b0, 1'b1);
    end
    n_cmp++;
    if (got.size() != 16 || busy_cycles != 16) begin
      n_err++;
      $display("FAIL b2b_gapfree: got %0d words %0d in first 16 cycles want 16 16",
               got.size(), busy_cycles);
    end
    for (int i = 0; i < 16 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== ((i < 8) ? 8'(i) : 8'(8'h10 + i))) begin
        n_err++;
        $display("FAIL b2b_data%0d: got %h want %h", i, got[i],
                 (i < 8) ? 8'(i) : 8'(8'h10 + i));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(1'b1, D0, 4'd0, 1'b0, 1'b1);
    tick(1'b0, 64'h0, 4'd0, 1'b0, 1'b1);
    tick(1'b1, D1, 4'd0, 1'b0, 1'b1);
    tick(1'b0, 64'h0, 4'd0, 1'b0, 1'b1);
    n_cmp++;
    if (dout !== 8'h03 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_pre: got dout=%h busy=%b want 03 1", dout, busy);
    end
    begin_wr = 1'b1;
    do_reset();
    n_cmp++;
    if (obs_vec() !== 12'h000) begin
      n_err++;
      $display("FAIL rstmid_zero: got %h want 000", obs_vec());
    end
    for (int c = 0; c < 3; c++) begin
      tick(1'b0, 64'h0, 4'd0, 1'b0, 1'b1);
      n_cmp++;
      if (outen !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL rstmid_quiet: got outen=%b busy=%b want 0 0", outen, busy);
      end
    end
    tick(1'b1, D0, 4'd0, 1'b0, 1'b1);
    n_cmp++;
    if (outen !== 1'b1 || dout !== 8'h00) begin
      n_err++;
      $display("FAIL rstmid_restart: got outen=%b dout=%h want 1 00", outen, dout);
    end
  endtask

  task automatic test_boundary();
    do_reset();
    tick(1'b1, D0, 4'd2, 1'b0, 1'b1);
    tick(1'b0, 64'h0, 4'd0, 1'b0, 1'b1);
    n_cmp++;
    if (dout !== 8'h01 || last !== 1'b1) begin
      n_err++;
      $display("FAIL bnd_last: got dout=%h last=%b want 01 1", dout, last);
    end
    tick(1'b1, D1, 4'd0, 1'b0, 1'b1);
    n_cmp++;
    if (outen !== 1'b1 || dout !== 8'h18 || overflow !== 1'b0 || last !== 1'b0) begin
      n_err++;
      $display("FAIL bnd_chain: got outen=%b dout=%h ovf=%b last=%b want 1 18 0 0",
               outen, dout, overflow, last);
    end
    for (int c = 0; c < 9; c++) begin
      n_cmp++;
      if (((obs_vec() ^ exp_vec()) & exp_mask()) !== 12'h000) begin
        n_err++;
        $display("FAIL bnd_model: got %h want %h", obs_vec(), exp_vec());
      end
      tick(1'b0, 64'h0, 4'd0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_random();
    logic [3:0] l;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      l = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 9));
      tick(($urandom_range(0, 3) == 0), {$urandom, $urandom}, l,
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      n_cmp++;
      if (((obs_vec() ^ exp_vec()) & exp_mask()) !== 12'h000) begin
        n_err++;
        $display("FAIL random c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; begin_wr = 1'b0; din = '0; len = '0; rev = 1'b0; out_ready = 1'b0;
    ovf_exp = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_len_dir();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
